// File: rtl/mha_pkg.sv
// Shared definitions for the systolic-array controller: FSM state encoding,
// default array geometry and width helpers.
package mha_pkg;

    typedef logic [2:0] sa_state_t;

    localparam sa_state_t ST_IDLE  = 3'd0;
    localparam sa_state_t ST_CLEAR = 3'd1;
    localparam sa_state_t ST_FEED  = 3'd2;
    localparam sa_state_t ST_DRAIN = 3'd3;
    localparam sa_state_t ST_DONE  = 3'd4;

    localparam int MHA_D_W   = 16;
    localparam int MHA_N     = 4;
    localparam int MHA_K_MAX = 64;

    // Bit width needed to index 'value' distinct items, never less than one bit.
    function automatic int sa_width(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

    localparam int MHA_K_W = sa_width(MHA_K_MAX + 1);
    localparam int MHA_A_W = sa_width(MHA_K_MAX);

endpackage

// File: rtl/sa_skew_reg.sv
// N-lane valid skew: lane i is the input delayed by i*STEP_CYC cycles, so each
// array row/column sees its operands one k-step after its neighbour.
module sa_skew_reg #(
    parameter int N        = 4,
    parameter int STEP_CYC = 4
) (
    input  logic         I_CLK,
    input  logic         I_ASYN_RSTN,
    input  logic         I_VLD,
    output logic [N-1:0] O_VLD
);

    localparam int L = (N - 1) * STEP_CYC;

    assign O_VLD[0] = I_VLD;

    generate
        if (L > 0) begin : g_shift
            logic [L-1:0] sr_q;

            // Single delay line; lanes tap it at multiples of STEP_CYC.
            always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
                if (!I_ASYN_RSTN) begin
                    sr_q <= '0;
                end else begin
                    sr_q[0] <= I_VLD;
                    for (int j = 1; j < L; j++) begin
                        sr_q[j] <= sr_q[j-1];
                    end
                end
            end

            for (genvar i = 1; i < N; i++) begin : g_lane
                assign O_VLD[i] = sr_q[i*STEP_CYC-1];
            end
        end
    endgenerate

endmodule

// File: rtl/sa_ctrl.sv
// Systolic-array tile controller: clears the PEs, streams K operand reads with
// a skewed valid window, drains the array and pulses DONE.
// Optional busy-cycle counter enabled by defining SA_CTRL_PERF_CNT_EN.
module sa_ctrl
    import mha_pkg::*;
#(
    parameter int D_W      = MHA_D_W,
    parameter int N        = MHA_N,
    parameter int K_MAX    = MHA_K_MAX,
    parameter int STEP_CYC = 4,
    localparam int K_W     = sa_width(K_MAX + 1),
    localparam int A_W     = sa_width(K_MAX)
) (
    input  logic           I_CLK,
    input  logic           I_ASYN_RSTN,
    input  logic           I_START,
    input  logic [K_W-1:0] I_K,
    output logic           O_BUSY,
    output logic           O_DONE,
    output logic           O_PE_SRSTN,
    output logic           O_RD_EN,
    output logic [A_W-1:0] O_RD_ADDR,
    output logic [N-1:0]   O_EDGE_VLD,
    output logic [31:0]    O_CYC_CNT
);

    localparam int S_W = sa_width(K_MAX + 2 * N);
    localparam int C_W = sa_width(STEP_CYC);
    localparam logic [C_W-1:0] CYC_LAST    = C_W'(STEP_CYC - 1);
    localparam logic [S_W-1:0] DRAIN_STEPS = S_W'(2 * N - 1);

    generate
        if (D_W < 1 || N < 1 || K_MAX < 1 || STEP_CYC < 3) begin : g_param_check
            $error("sa_ctrl: invalid parameter set");
        end
    endgenerate

    sa_state_t      state_q, state_d;
    logic [C_W-1:0] cyc_q, cyc_d;
    logic [S_W-1:0] step_q, step_d;
    logic [S_W-1:0] feed_end_q, feed_end_d;
    logic [S_W-1:0] drain_end_s;
    logic           start_ok_s;
    logic           step_wrap_s;

    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           pe_srstn_q, pe_srstn_d;
    logic           rd_en_q, rd_en_d;
    logic [A_W-1:0] rd_addr_q, rd_addr_d;
    logic           vld_q, vld_d;

    assign start_ok_s  = I_START && (I_K != '0) && (I_K <= K_W'(K_MAX));
    assign step_wrap_s = (cyc_q == CYC_LAST);
    // Drain runs 2*(N-1) steps plus one extra step after the last feed step.
    assign drain_end_s = feed_end_q + DRAIN_STEPS;

    // Next-state and step/cycle counter logic.
    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        step_d     = step_q;
        feed_end_d = feed_end_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_d    = ST_CLEAR;
                    feed_end_d = S_W'(I_K) - S_W'(1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                state_d = ST_FEED;
                cyc_d   = '0;
                step_d  = '0;
            end
            ST_FEED: begin
                if (step_wrap_s) begin
                    cyc_d  = '0;
                    step_d = step_q + S_W'(1);
                    if (step_q == feed_end_q) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_FEED;
                    end
                end else begin
                    cyc_d = cyc_q + C_W'(1);
                end
            end
            ST_DRAIN: begin
                if (step_wrap_s) begin
                    cyc_d  = '0;
                    step_d = step_q + S_W'(1);
                    if (step_q == drain_end_s) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else begin
                    cyc_d = cyc_q + C_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cyc_d   = '0;
                step_d  = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cyc_d   = '0;
                step_d  = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
        pe_srstn_d = (state_d != ST_CLEAR);
        rd_en_d    = (state_d == ST_FEED) && (cyc_d == '0);
        vld_d      = (state_d == ST_FEED) && (cyc_d != '0);
        if (rd_en_d) begin
            rd_addr_d = A_W'(step_d);
        end else begin
            rd_addr_d = rd_addr_q;
        end
    end

    // State, counter and output registers.
    always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
        if (!I_ASYN_RSTN) begin
            state_q    <= ST_IDLE;
            cyc_q      <= '0;
            step_q     <= '0;
            feed_end_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pe_srstn_q <= 1'b1;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            vld_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            step_q     <= step_d;
            feed_end_q <= feed_end_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pe_srstn_q <= pe_srstn_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            vld_q      <= vld_d;
        end
    end

    sa_skew_reg #(
        .N        (N),
        .STEP_CYC (STEP_CYC)
    ) u_skew (
        .I_CLK       (I_CLK),
        .I_ASYN_RSTN (I_ASYN_RSTN),
        .I_VLD       (vld_q),
        .O_VLD       (O_EDGE_VLD)
    );

    assign O_BUSY     = busy_q;
    assign O_DONE     = done_q;
    assign O_PE_SRSTN = pe_srstn_q;
    assign O_RD_EN    = rd_en_q;
    assign O_RD_ADDR  = rd_addr_q;

`ifdef SA_CTRL_PERF_CNT_EN
    logic [31:0] cyc_cnt_q;

    // Saturating busy-cycle counter; only reset clears it.
    always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
        if (!I_ASYN_RSTN) begin
            cyc_cnt_q <= 32'd0;
        end else if (busy_q && (cyc_cnt_q != 32'hFFFF_FFFF)) begin
            cyc_cnt_q <= cyc_cnt_q + 32'd1;
        end else begin
            cyc_cnt_q <= cyc_cnt_q;
        end
    end

    assign O_CYC_CNT = cyc_cnt_q;
`else
    assign O_CYC_CNT = 32'd0;
`endif

endmodule

// File: tb/tb_sa_ctrl.sv
// Scoreboard bench for sa_ctrl (N=4, STEP_CYC=4, K_MAX=64): stimulus pushes
// expected read/clear/done events, a negedge monitor pops and compares them.
module tb_sa_ctrl;
    import mha_pkg::*;

    localparam int N  = 4;
    localparam int S  = 4;

    typedef struct {
        int cyc;
        int addr;
    } rd_exp_t;

    logic                I_CLK = 1'b0;
    logic                I_ASYN_RSTN;
    logic                I_START;
    logic [MHA_K_W-1:0]  I_K;
    logic                O_BUSY;
    logic                O_DONE;
    logic                O_PE_SRSTN;
    logic                O_RD_EN;
    logic [MHA_A_W-1:0]  O_RD_ADDR;
    logic [N-1:0]        O_EDGE_VLD;
    logic [31:0]         O_CYC_CNT;

    int      n_cmp = 0;
    int      n_err = 0;
    int      cyc = 0;
    bit      mon_en = 1'b0;
    int      last_clr = 0;
    int      last_done = 0;
    int      done_seen = 0;
    int      e_first [N];
    int      e_cnt [N];
    logic [N-1:0]       e_prev = '0;
    logic [MHA_A_W-1:0] prev_addr = '0;

    rd_exp_t rd_q[$];
    int      srst_q[$];
    int      done_q[$];

    sa_ctrl #(
        .D_W      (16),
        .N        (N),
        .K_MAX    (64),
        .STEP_CYC (S)
    ) dut (
        .I_CLK       (I_CLK),
        .I_ASYN_RSTN (I_ASYN_RSTN),
        .I_START     (I_START),
        .I_K         (I_K),
        .O_BUSY      (O_BUSY),
        .O_DONE      (O_DONE),
        .O_PE_SRSTN  (O_PE_SRSTN),
        .O_RD_EN     (O_RD_EN),
        .O_RD_ADDR   (O_RD_ADDR),
        .O_EDGE_VLD  (O_EDGE_VLD),
        .O_CYC_CNT   (O_CYC_CNT)
    );

    always #5 I_CLK = ~I_CLK;

    always @(posedge I_CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents an event.
    initial begin
        rd_exp_t e;
        forever begin
            @(negedge I_CLK);
            if (mon_en) begin
                if (!O_PE_SRSTN) begin
                    for (int i = 0; i < N; i++) begin
                        e_first[i] = -1;
                        e_cnt[i]   = 0;
                    end
                    if (srst_q.size() == 0) chk("srst_unexpected", cyc, -1);
                    else chk("srst_cyc", cyc, srst_q.pop_front());
                end
                if (O_RD_EN) begin
                    if (rd_q.size() == 0) begin
                        chk("rd_unexpected", cyc, -1);
                    end else begin
                        e = rd_q.pop_front();
                        chk("rd_cyc", cyc, e.cyc);
                        chk("rd_addr", O_RD_ADDR, e.addr);
                    end
                end else begin
                    chk("rd_addr_hold", O_RD_ADDR, prev_addr);
                end
                if (O_DONE) begin
                    done_seen++;
                    last_done = cyc;
                    if (done_q.size() == 0) chk("done_unexpected", cyc, -1);
                    else chk("done_cyc", cyc, done_q.pop_front());
                end
                if (!O_BUSY || !O_PE_SRSTN || O_DONE)
                    chk("edge_zero_outside_run", O_EDGE_VLD, 0);
                for (int i = 0; i < N; i++) begin
                    if (O_EDGE_VLD[i]) begin
                        e_cnt[i]++;
                        if (!e_prev[i] && e_first[i] < 0) e_first[i] = cyc;
                    end
                end
            end
            e_prev    = O_EDGE_VLD;
            prev_addr = O_RD_ADDR;
        end
    end

    // Drives a one-cycle start at the current (negedge) time.
    task automatic start_run(input int k, input bit accept);
        rd_exp_t e;
        I_START = 1'b1;
        I_K     = k[MHA_K_W-1:0];
        if (accept) begin
            last_clr = cyc + 1;
            srst_q.push_back(last_clr);
            for (int s = 0; s < k; s++) begin
                e.cyc  = last_clr + 1 + s * S;
                e.addr = s;
                rd_q.push_back(e);
            end
            done_q.push_back(last_clr + 1 + (k + 2 * (N - 1)) * S + S);
        end
        @(negedge I_CLK);
        I_START = 1'b0;
    endtask

    // Returns at the negedge where O_DONE is high (plus #1).
    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int n = 0; n < 400 && !seen; n++) begin
            @(negedge I_CLK);
            if (O_DONE) seen = 1'b1;
        end
        chk({name, "_done_seen"}, seen, 1);
        #1;
        chk({name, "_rd_left"}, rd_q.size(), 0);
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_busy"}, O_BUSY, 0);
        chk({name, "_done"}, O_DONE, 0);
        chk({name, "_srstn"}, O_PE_SRSTN, 1);
        chk({name, "_rd_en"}, O_RD_EN, 0);
        chk({name, "_rd_addr"}, O_RD_ADDR, 0);
        chk({name, "_edge"}, O_EDGE_VLD, 0);
        chk({name, "_cnt"}, O_CYC_CNT, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        I_ASYN_RSTN = 1'b0;
        I_START     = 1'b0;
        I_K         = '0;
        repeat (3) @(negedge I_CLK);
        chk_reset_vals("reset");
        I_ASYN_RSTN = 1'b1;
        mon_en      = 1'b1;
        @(negedge I_CLK);

        // Illegal K values are ignored.
        start_run(0, 1'b0);
        chk("k0_busy", O_BUSY, 0);
        start_run(65, 1'b0);
        chk("k65_busy", O_BUSY, 0);
        start_run(127, 1'b0);
        repeat (3) @(negedge I_CLK);
        chk("kbad_busy", O_BUSY, 0);
        chk("kbad_srstn", O_PE_SRSTN, 1);

        // K=3 tile: reads at 4-cycle spacing, DONE 41 cycles after CLEAR.
        start_run(3, 1'b1);
        chk("k3_busy", O_BUSY, 1);
        wait_done("k3");
        chk("k3_latency", last_done - last_clr, 41);
        chk("k3_edge0_first", e_first[0] - last_clr, 2);
        chk("k3_edge1_skew", e_first[1] - e_first[0], 4);
        chk("k3_edge2_skew", e_first[2] - e_first[0], 8);
        chk("k3_edge3_skew", e_first[3] - e_first[0], 12);
        for (int i = 0; i < N; i++) chk("k3_edge_cnt", e_cnt[i], 9);
        @(negedge I_CLK);
        chk("k3_idle_busy", O_BUSY, 0);

        // Extra starts while busy and at DONE are ignored.
        d0 = done_seen;
        start_run(2, 1'b1);
        repeat (3) @(negedge I_CLK);
        for (int j = 0; j < 4; j++) begin
            I_START = 1'b1;
            I_K     = 7'd5;
            @(negedge I_CLK);
            I_START = 1'b0;
            repeat (5) @(negedge I_CLK);
        end
        wait_done("k2");
        chk("k2_latency", last_done - last_clr, 37);
        I_START = 1'b1;
        I_K     = 7'd1;
        @(negedge I_CLK);
        I_START = 1'b0;
        chk("start_at_done_busy", O_BUSY, 0);
        repeat (20) @(negedge I_CLK);
        chk("k2_single_done", done_seen - d0, 1);
        chk("k2_busy_after", O_BUSY, 0);

        // Asynchronous reset during FEED step 1, then a clean restart.
        start_run(3, 1'b1);
        repeat (6) @(posedge I_CLK);
        #1;
        chk("abort_addr_step1", O_RD_ADDR, 1);
        mon_en      = 1'b0;
        I_ASYN_RSTN = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        rd_q.delete();
        srst_q.delete();
        done_q.delete();
        repeat (2) @(negedge I_CLK);
        I_ASYN_RSTN = 1'b1;
        mon_en      = 1'b1;
        d0 = done_seen;
        repeat (60) @(negedge I_CLK);
        chk("abort_no_done", done_seen - d0, 0);
        chk("abort_busy", O_BUSY, 0);
        start_run(1, 1'b1);
        wait_done("restart_k1");
        chk("k1_latency", last_done - last_clr, 33);

        // Two back-to-back K=1 runs for the busy-cycle counter.
        @(negedge I_CLK);
        I_ASYN_RSTN = 1'b0;
        @(negedge I_CLK);
        I_ASYN_RSTN = 1'b1;
        start_run(1, 1'b1);
        wait_done("perf_a");
        @(negedge I_CLK);
        start_run(1, 1'b1);
        wait_done("perf_b");
        repeat (4) @(negedge I_CLK);
`ifdef SA_CTRL_PERF_CNT_EN
        chk("perf_cnt", O_CYC_CNT, 68);
`else
        chk("perf_cnt_off", O_CYC_CNT, 0);
`endif
        chk("final_srst_left", srst_q.size(), 0);
        chk("final_done_left", done_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
